load_store_unit: RTL

Initiator side of the data-memory interface: sits in the MEM stage, accepts one load/store request at a time from the pipeline, and drives the word-only data memory's read/write ports. Loads are sign- or zero-extended. SB/SH stores become a read-modify-write, because the memory writes whole words only. Alignment and range faults are detected before any memory access is issued.

---
 rtl/load_store_unit_pkg.sv | 9 +
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit_lane_align.sv | 25 ++
 rtl/load_store_unit.sv | 79 +++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: RV32I load/store funct3 codes and the unit's FSM state type
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} lsu_state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and word-only data-memory port bundle
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    modport slave (
        input  req_valid, req_load, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_read, mem_write, mem_address, mem_write_data
    );
    modport master (
        output req_valid, req_load, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte/half lane extraction with extension, and sub-word merge for read-modify-write
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    assign sh = {lane, 3'b000};
    assign b  = 8'(word >> sh);
    assign h  = 16'(word >> sh);
    assign rdata = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                   funct3 == F3_H  ? {{16{h[15]}}, h} :
                   funct3 == F3_BU ? {24'd0, b}       :
                   funct3 == F3_HU ? {16'd0, h}       : word;
    assign mask   = (funct3 == F3_B ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word-only data memory; SB/SH become read-modify-write.
// Define LSU_RANGE_CHECK_EN to fault addresses beyond MEM_WORDS words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    lsu_state_t  state, next;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] addr, wd, rdata_q, rdata, merged;
    logic        fault_q, illegal, misaligned, out_of_range, fault;
    assign illegal = bus.req_load ? (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11)
                                  : bus.req_funct3 > F3_W;
    assign misaligned = bus.req_funct3[1:0] == 2'd1 ? bus.req_addr[0] :
                        bus.req_funct3[1:0] == 2'd2 ? |bus.req_addr[1:0] : 1'b0;
    assign out_of_range = RANGE_EN && ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
    assign fault = illegal || misaligned || out_of_range;
    always_comb begin
        next = state;
        case (state)
            IDLE:                next = !bus.req_valid ? IDLE : fault ? RESP : bus.req_load ? LOAD :
                                        bus.req_funct3 == F3_W ? STORE : RMW_RD;
            LOAD, STORE, RMW_WR: next = RESP;
            RMW_RD:              next = RMW_WR;
            default:             next = IDLE;
        endcase
    end
    // rsp_rdata/rsp_fault only change on entry to RESP so they hold between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            f3      <= '0;
            lane    <= '0;
            addr    <= '0;
            wd      <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && bus.req_valid) begin
                f3   <= bus.req_funct3;
                lane <= bus.req_addr[1:0];
                addr <= {bus.req_addr[31:2], 2'b00};
                wd   <= bus.req_wdata;
            end
            if (state == RMW_RD) wd <= merged;
            if (next == RESP) begin
                fault_q <= state == IDLE;
                rdata_q <= state == LOAD ? rdata : '0;
            end
        end
    end
    lsu_lane_align u_align (
        .word   (bus.mem_read_data),
        .wdata  (wd),
        .lane   (lane),
        .funct3 (f3),
        .rdata  (rdata),
        .merged (merged)
    );
    assign bus.req_ready      = state == IDLE;
    assign bus.rsp_valid      = state == RESP;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_fault      = fault_q;
    assign bus.mem_read       = state == LOAD || state == RMW_RD;
    assign bus.mem_write      = state == STORE || state == RMW_WR;
    assign bus.mem_address    = addr;
    assign bus.mem_write_data = wd;
endmodule
